hms_time_cnt: RTL and testbench

//  Time-of-day counter (hh:mm:ss) with button-driven set mode.

---
 rtl/hms_time_cnt.sv | 128 ++++++++++++
 tb/tb_hms_time_cnt.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hms_time_cnt.sv
// Time-of-day counter (hh:mm:ss) with a button-driven set mode.
// Runs on a 1 Hz tick in CLOCK mode; the SET_* modes increment one field at a time.
module hms_time_cnt #(
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_mode,
  input  logic       i_incr,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [5:0] o_hour,
  output logic [1:0] o_mode,
  output logic [5:0] o_dp,
  output logic       o_day_pulse
);

  localparam int unsigned FW = 6;
  localparam logic [FW-1:0] SEC_LAST  = FW'(59);
  localparam logic [FW-1:0] MIN_LAST  = FW'(59);
  localparam logic [FW-1:0] HOUR_LAST = FW'(HOUR_MAX);

  typedef enum logic [1:0] {
    CLOCK    = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } mode_t;

  mode_t         state, state_nxt;
  logic [FW-1:0] sec_nxt, min_nxt, hour_nxt, dp_nxt;
  logic          day_nxt;
  logic          set_incr;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= CLOCK;
    else     state <= state_nxt;
  end

  // Next state: i_mode cycles through the four modes in order
  always_comb begin
    state_nxt = state;
    if (i_mode) begin
      unique case (state)
        CLOCK:    state_nxt = SET_SEC;
        SET_SEC:  state_nxt = SET_MIN;
        SET_MIN:  state_nxt = SET_HOUR;
        SET_HOUR: state_nxt = CLOCK;
        default:  state_nxt = CLOCK;
      endcase
    end
  end

  // A mode press in the same cycle wins over an increment
  assign set_incr = i_incr && !i_mode;

  // Output / datapath next values
  always_comb begin
    sec_nxt  = o_sec;
    min_nxt  = o_min;
    hour_nxt = o_hour;
    day_nxt  = 1'b0;
    dp_nxt   = 6'b000000;

    unique case (state)
      CLOCK: begin
        if (i_tick) begin
          if (o_sec >= SEC_LAST) begin
            sec_nxt = '0;
            if (o_min >= MIN_LAST) begin
              min_nxt = '0;
              if (o_hour >= HOUR_LAST) begin
                hour_nxt = '0;
                day_nxt  = 1'b1;
              end else begin
                hour_nxt = o_hour + FW'(1);
              end
            end else begin
              min_nxt = o_min + FW'(1);
            end
          end else begin
            sec_nxt = o_sec + FW'(1);
          end
        end
      end
      SET_SEC: begin
        if (set_incr) sec_nxt = (o_sec >= SEC_LAST) ? '0 : o_sec + FW'(1);
      end
      SET_MIN: begin
        if (set_incr) min_nxt = (o_min >= MIN_LAST) ? '0 : o_min + FW'(1);
      end
      SET_HOUR: begin
        if (set_incr) hour_nxt = (o_hour >= HOUR_LAST) ? '0 : o_hour + FW'(1);
      end
      default: ;
    endcase

    unique case (state_nxt)
      CLOCK:    dp_nxt = 6'b000000;
      SET_SEC:  dp_nxt = 6'b000011;
      SET_MIN:  dp_nxt = 6'b001100;
      SET_HOUR: dp_nxt = 6'b110000;
      default:  dp_nxt = 6'b000000;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      o_sec       <= '0;
      o_min       <= '0;
      o_hour      <= '0;
      o_dp        <= '0;
      o_day_pulse <= 1'b0;
    end else begin
      o_sec       <= sec_nxt;
      o_min       <= min_nxt;
      o_hour      <= hour_nxt;
      o_dp        <= dp_nxt;
      o_day_pulse <= day_nxt;
    end
  end

  assign o_mode = state;

endmodule

// File: tb/tb_hms_time_cnt.sv
// Self-checking bench for hms_time_cnt: directed scenarios plus random traffic
// compared every cycle against a seconds-of-day reference model.
module tb_hms_time_cnt;

  localparam int unsigned HOUR_MAX = 23;
  localparam int DAY_SECS = (HOUR_MAX + 1) * 3600;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_tick = 1'b0;
  logic       i_mode = 1'b0;
  logic       i_incr = 1'b0;
  logic [5:0] o_sec, o_min, o_hour, o_dp;
  logic [1:0] o_mode;
  logic       o_day_pulse;

  int total = 0;
  int bad = 0;

  int m_sec, m_min, m_hour, m_mode, m_dp, m_day;

  hms_time_cnt #(.HOUR_MAX(HOUR_MAX)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_mode(i_mode), .i_incr(i_incr),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_mode(o_mode),
    .o_dp(o_dp), .o_day_pulse(o_day_pulse)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: clock time as seconds of day; set mode edits one field modulo its range
  task automatic model_step(input bit r, input bit t, input bit m, input bit n);
    int secs;
    m_day = 0;
    if (r) begin
      m_sec = 0; m_min = 0; m_hour = 0; m_mode = 0;
    end else begin
      if (m_mode == 0 && t) begin
        secs = m_hour * 3600 + m_min * 60 + m_sec + 1;
        if (secs == DAY_SECS) m_day = 1;
        secs = secs % DAY_SECS;
        m_hour = secs / 3600;
        m_min  = (secs / 60) % 60;
        m_sec  = secs % 60;
      end else if (m_mode != 0 && n && !m) begin
        case (m_mode)
          1: m_sec  = (m_sec + 1) % 60;
          2: m_min  = (m_min + 1) % 60;
          default: m_hour = (m_hour + 1) % (HOUR_MAX + 1);
        endcase
      end
      if (m) m_mode = (m_mode + 1) % 4;
    end
    case (m_mode)
      1: m_dp = 3;
      2: m_dp = 12;
      3: m_dp = 48;
      default: m_dp = 0;
    endcase
  endtask

  task automatic cycle(input bit r, input bit t, input bit m, input bit n);
    @(negedge clk);
    rst = r; i_tick = t; i_mode = m; i_incr = n;
    @(posedge clk);
    #1;
    model_step(r, t, m, n);
    check("sec",  int'(o_sec),  m_sec);
    check("min",  int'(o_min),  m_min);
    check("hour", int'(o_hour), m_hour);
    check("mode", int'(o_mode), m_mode);
    check("dp",   int'(o_dp),   m_dp);
    check("day",  int'(o_day_pulse), m_day);
    rst = 0; i_tick = 0; i_mode = 0; i_incr = 0;
  endtask

  task automatic repeat_cycle(input int cnt, input bit t, input bit m, input bit n);
    for (int i = 0; i < cnt; i++) cycle(1'b0, t, m, n);
  endtask

  // From a reset clock, walk through the set modes and return to CLOCK
  task automatic preload(input int h, input int mi, input int s);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat_cycle(s, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat_cycle(mi, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat_cycle(h, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int day_hits;

    // Reset state and 61 ticks
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_time", int'(o_hour) * 3600 + int'(o_min) * 60 + int'(o_sec), 0);
    day_hits = 0;
    for (int i = 0; i < 61; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      day_hits += int'(o_day_pulse);
    end
    check("t1_min", int'(o_min), 1);
    check("t1_sec", int'(o_sec), 1);
    check("t1_day_hits", day_hits, 0);

    // Day rollover from 23:59:59
    preload(23, 59, 59);
    check("t2_pre", int'(o_hour) * 3600 + int'(o_min) * 60 + int'(o_sec), DAY_SECS - 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("t2_zero", int'(o_hour) + int'(o_min) + int'(o_sec), 0);
    check("t2_day_hi", int'(o_day_pulse), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_day_lo", int'(o_day_pulse), 0);

    // Seconds wrap in set mode without carry, ticks frozen
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat_cycle(62, 1'b0, 1'b0, 1'b1);
    repeat_cycle(5, 1'b1, 1'b0, 1'b0);
    check("t3_sec", int'(o_sec), 2);
    check("t3_min", int'(o_min), 0);
    check("t3_dp", int'(o_dp), 6'b000011);

    // Hour wrap in SET_HOUR, then back to CLOCK
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat_cycle(3, 1'b0, 1'b1, 1'b0);
    repeat_cycle(25, 1'b0, 1'b0, 1'b1);
    check("t4_hour", int'(o_hour), 1);
    check("t4_mode", int'(o_mode), 3);
    check("t4_dp", int'(o_dp), 6'b110000);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_mode_back", int'(o_mode), 0);
    check("t4_dp_back", int'(o_dp), 0);

    // Simultaneous events
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    repeat_cycle(3, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_mode_incr_mode", int'(o_mode), 2);
    check("t5_mode_incr_sec", int'(o_sec), 3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat_cycle(5, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("t5_tick_mode_sec", int'(o_sec), 6);
    check("t5_tick_mode_mode", int'(o_mode), 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("t5_incr_in_clock", int'(o_sec), 7);

    // Reset mid-set with a concurrent increment
    preload(12, 34, 56);
    repeat_cycle(2, 1'b0, 1'b1, 1'b0);
    check("t6_pre_mode", int'(o_mode), 2);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("t6_time", int'(o_hour) + int'(o_min) + int'(o_sec), 0);
    check("t6_mode", int'(o_mode), 0);
    check("t6_dp", int'(o_dp), 0);

    // Random traffic
    for (int i = 0; i < 4000; i++)
      cycle(($urandom % 300) == 0, ($urandom % 3) == 0, ($urandom % 8) == 0,
            ($urandom % 2) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
